// File: rtl/router_sync_multi_if.sv
// Bundle between the router FSM, the output FIFOs, the destinations and the
// write-side synchronizer. master = FSM/FIFO/destination side, slave = sync.
// Optional macro ROUTER_SYNC_SR_COUNT_EN adds the sr_count soft-reset counters.
interface router_sync_multi_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    logic              det_addr;
    logic [ADDR_W-1:0] din;
    logic              wr_en_reg;
    logic [NUM_CH-1:0] fifo_full_in;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] read_en;
    logic [NUM_CH-1:0] wr_en;
    logic              fifo_full;
    logic [NUM_CH-1:0] valid_out;
    logic [NUM_CH-1:0] soft_rst;
    logic              addr_err;
`ifdef ROUTER_SYNC_SR_COUNT_EN
    logic [NUM_CH*4-1:0] sr_count;

    modport master (
        output det_addr, din, wr_en_reg, fifo_full_in, fifo_empty, read_en,
        input  wr_en, fifo_full, valid_out, soft_rst, addr_err, sr_count
    );
    modport slave (
        input  det_addr, din, wr_en_reg, fifo_full_in, fifo_empty, read_en,
        output wr_en, fifo_full, valid_out, soft_rst, addr_err, sr_count
    );
`else
    modport master (
        output det_addr, din, wr_en_reg, fifo_full_in, fifo_empty, read_en,
        input  wr_en, fifo_full, valid_out, soft_rst, addr_err
    );
    modport slave (
        input  det_addr, din, wr_en_reg, fifo_full_in, fifo_empty, read_en,
        output wr_en, fifo_full, valid_out, soft_rst, addr_err
    );
`endif
endinterface

// File: rtl/router_sync_multi.sv
// Router write-side synchronizer for NUM_CH output FIFOs: latches the header
// address, steers one-hot write enables, returns the addressed FIFO's full
// flag and soft-resets any FIFO left valid but unread for TIMEOUT cycles.
// Optional macro ROUTER_SYNC_SR_COUNT_EN adds per-channel saturating
// soft-reset pulse counters on bus.sr_count.

// One channel's read-timeout watchdog.
module router_sync_multi_ch #(
    parameter int TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld,
    input  logic       rd,
`ifdef ROUTER_SYNC_SR_COUNT_EN
    output logic [3:0] sr_cnt,
`endif
    output logic       soft_rst
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer;

    // Count unread-valid cycles; any read or empty FIFO restarts the window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer    <= '0;
            soft_rst <= 1'b0;
        end else if (vld && !rd) begin
            if (timer == TMAX) begin
                timer    <= '0;
                soft_rst <= 1'b1;
            end else begin
                timer    <= timer + TW'(1);
                soft_rst <= 1'b0;
            end
        end else begin
            timer    <= '0;
            soft_rst <= 1'b0;
        end
    end

`ifdef ROUTER_SYNC_SR_COUNT_EN
    // Saturating tally of soft-reset pulses, bumped on the edge after each.
    always_ff @(posedge clk) begin
        if (!rst)
            sr_cnt <= 4'd0;
        else if (soft_rst && sr_cnt != 4'd15)
            sr_cnt <= sr_cnt + 4'd1;
    end
`endif
endmodule

module router_sync_multi #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    router_sync_multi_if.slave   bus
);
    logic [ADDR_W-1:0] addr_q;
    logic              addr_vld_q;
    logic              addr_err_q;
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] wr;
    logic              full;
    logic [NUM_CH-1:0] srst;

    // Header address latch; an out-of-range address disables steering and
    // raises a one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else if (bus.det_addr) begin
            addr_q     <= bus.din;
            addr_vld_q <= 32'(bus.din) <  NUM_CH;
            addr_err_q <= 32'(bus.din) >= NUM_CH;
        end else begin
            addr_err_q <= 1'b0;
        end
    end

    // Steer the write request and select the full flag of the latched channel.
    always_comb begin
        wr   = '0;
        full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_vld_q && addr_q == ADDR_W'(i)) begin
                wr[i] = bus.wr_en_reg;
                full  = bus.fifo_full_in[i];
            end
        end
    end

    assign vld           = ~bus.fifo_empty;
    assign bus.valid_out = vld;
    assign bus.wr_en     = wr;
    assign bus.fifo_full = full;
    assign bus.addr_err  = addr_err_q;
    assign bus.soft_rst  = srst;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        router_sync_multi_ch #(.TIMEOUT(TIMEOUT)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .vld      (vld[g]),
            .rd       (bus.read_en[g]),
`ifdef ROUTER_SYNC_SR_COUNT_EN
            .sr_cnt   (bus.sr_count[g*4 +: 4]),
`endif
            .soft_rst (srst[g])
        );
    end
endmodule
